// File: rtl/puf_pkg.sv
// Shared state encoding, width helper and default parameters for the PUF challenge sequencer.
package puf_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCreate  = 3'd1,
    StCapture = 3'd2,
    StSettle  = 3'd3,
    StEmit    = 3'd4,
    StDone    = 3'd5
  } state_e;

  localparam int unsigned DefDataW         = 32;
  localparam int unsigned DefAddrW         = 10;
  localparam int unsigned DefNumChal       = 4;
  localparam int unsigned DefAddrStep      = 1;
  localparam int unsigned DefRepeat        = 5;
  localparam int unsigned DefSettleCycles  = 150_000_000;
  localparam int unsigned DefTimeoutCycles = 1024;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/puf_bit_accum.sv
// Per-bit one-counters over the repeats of a challenge, with majority and instability decode.
module puf_bit_accum
  import puf_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned REPEAT = DefRepeat
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] maj_o,
  output logic [DATA_W-1:0] unstable_o
);

  localparam int unsigned CntW = width_of(REPEAT + 1);

  logic [CntW-1:0] cnt_q [DATA_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < DATA_W; j++) cnt_q[j] <= '0;
    end else if (clr_i) begin
      for (int j = 0; j < DATA_W; j++) cnt_q[j] <= '0;
    end else if (acc_i) begin
      for (int j = 0; j < DATA_W; j++) cnt_q[j] <= cnt_q[j] + CntW'(word_i[j]);
    end
  end

  // Strict majority: an even-REPEAT tie resolves to 0.
  always_comb begin
    maj_o      = '0;
    unstable_o = '0;
    for (int j = 0; j < DATA_W; j++) begin
      maj_o[j]      = {cnt_q[j], 1'b0} > (CntW + 1)'(REPEAT);
      unstable_o[j] = (cnt_q[j] != '0) && (cnt_q[j] != CntW'(REPEAT));
    end
  end

endmodule

// File: rtl/puf_seq_ctrl.sv
// Multi-challenge PUF sequencer: drives rwc_ctrl for NUM_CHAL challenges x REPEAT collisions
// and streams one majority/instability result per challenge.
module puf_seq_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned NUM_CHAL       = DefNumChal,
  parameter int unsigned ADDR_STEP      = DefAddrStep,
  parameter int unsigned REPEAT         = DefRepeat,
  parameter int unsigned SETTLE_CYCLES  = DefSettleCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              rsp_sel,
  input  logic [DATA_W-1:0]                 cha_data_in,
  input  logic [ADDR_W-1:0]                 base_addr,
  output logic                              gen_enable,
  output logic [DATA_W-1:0]                 cha_data,
  output logic [ADDR_W-1:0]                 cha_addr,
  input  logic                              available,
  input  logic [DATA_W-1:0]                 rsp_write,
  input  logic [DATA_W-1:0]                 rsp_clean,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [width_of(NUM_CHAL)-1:0]     res_index,
  output logic [DATA_W-1:0]                 res_data,
  output logic [DATA_W-1:0]                 res_unstable,
  output logic                              res_err,
  output logic                              busy,
  output logic                              done,
  output logic [2:0]                        state
);

  localparam int unsigned IdxW  = width_of(NUM_CHAL);
  localparam int unsigned RepW  = width_of(REPEAT + 1);
  localparam int unsigned TcntW = width_of(TIMEOUT_CYCLES);
  localparam int unsigned ScntW = width_of(SETTLE_CYCLES);

  state_e            state_q;
  logic              gen_q, valid_q, done_q, busy_q, err_q, sel_q, res_err_q;
  logic [IdxW-1:0]   idx_q;
  logic [RepW-1:0]   rep_q;
  logic [TcntW-1:0]  tcnt_q;
  logic [ScntW-1:0]  scnt_q;
  logic [DATA_W-1:0] data_q, res_data_q, res_unst_q;
  logic [ADDR_W-1:0] addr_q;

  logic              acc_clr, acc_en;
  logic [DATA_W-1:0] rsp_word, maj, unst;

  assign rsp_word = sel_q ? rsp_clean : rsp_write;
  assign acc_en   = (state_q == StCapture);
  assign acc_clr  = ((state_q == StIdle) && start) || ((state_q == StEmit) && res_ready);

  puf_bit_accum #(
    .DATA_W (DATA_W),
    .REPEAT (REPEAT)
  ) u_accum (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (acc_clr),
    .acc_i      (acc_en),
    .word_i     (rsp_word),
    .maj_o      (maj),
    .unstable_o (unst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gen_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= 1'b0;
      res_err_q  <= 1'b0;
      idx_q      <= '0;
      rep_q      <= '0;
      tcnt_q     <= '0;
      scnt_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      res_data_q <= '0;
      res_unst_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            data_q  <= cha_data_in;
            addr_q  <= base_addr;
            sel_q   <= rsp_sel;
            idx_q   <= '0;
            rep_q   <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
            gen_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StCreate;
          end
        end
        StCreate: begin
          tcnt_q <= tcnt_q + TcntW'(1);
          if (available) begin
            gen_q   <= 1'b0;
            state_q <= StCapture;
          end else if (tcnt_q == TcntW'(TIMEOUT_CYCLES - 1)) begin
            // Remaining repeats are skipped; the result is flagged rather than partial.
            err_q      <= 1'b1;
            gen_q      <= 1'b0;
            valid_q    <= 1'b1;
            res_data_q <= '0;
            res_unst_q <= '1;
            res_err_q  <= 1'b1;
            state_q    <= StEmit;
          end
        end
        StCapture: begin
          rep_q   <= rep_q + RepW'(1);
          scnt_q  <= '0;
          state_q <= StSettle;
        end
        StSettle: begin
          if (scnt_q == ScntW'(SETTLE_CYCLES - 1)) begin
            if (rep_q < RepW'(REPEAT)) begin
              tcnt_q  <= '0;
              gen_q   <= 1'b1;
              state_q <= StCreate;
            end else begin
              valid_q    <= 1'b1;
              res_data_q <= maj;
              res_unst_q <= unst;
              res_err_q  <= 1'b0;
              state_q    <= StEmit;
            end
          end else begin
            scnt_q <= scnt_q + ScntW'(1);
          end
        end
        StEmit: begin
          if (res_ready) begin
            valid_q    <= 1'b0;
            res_data_q <= '0;
            res_unst_q <= '0;
            res_err_q  <= 1'b0;
            if (idx_q == IdxW'(NUM_CHAL - 1)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              addr_q  <= addr_q + ADDR_W'(ADDR_STEP);
              rep_q   <= '0;
              err_q   <= 1'b0;
              tcnt_q  <= '0;
              gen_q   <= 1'b1;
              state_q <= StCreate;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          gen_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gen_enable   = gen_q;
  assign cha_data     = data_q;
  assign cha_addr     = addr_q;
  assign res_valid    = valid_q;
  assign res_index    = idx_q;
  assign res_data     = res_data_q;
  assign res_unstable = res_unst_q;
  assign res_err      = res_err_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_puf_seq_ctrl.sv
// Directed bench for puf_seq_ctrl: stable, timeout/backpressure, noisy, rsp_clean and mid-run reset.
module tb_puf_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, rsp_sel, available, res_ready;
  logic [31:0] cha_data_in, rsp_write, rsp_clean;
  logic [9:0]  base_addr;
  logic        gen_enable, res_valid, res_err, busy, done;
  logic [31:0] cha_data, res_data, res_unstable;
  logic [9:0]  cha_addr;
  logic [0:0]  res_index;
  logic [2:0]  state;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  puf_seq_ctrl #(
    .DATA_W         (32),
    .ADDR_W         (10),
    .NUM_CHAL       (2),
    .ADDR_STEP      (1),
    .REPEAT         (5),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rsp_sel      (rsp_sel),
    .cha_data_in  (cha_data_in),
    .base_addr    (base_addr),
    .gen_enable   (gen_enable),
    .cha_data     (cha_data),
    .cha_addr     (cha_addr),
    .available    (available),
    .rsp_write    (rsp_write),
    .rsp_clean    (rsp_clean),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_index    (res_index),
    .res_data     (res_data),
    .res_unstable (res_unstable),
    .res_err      (res_err),
    .busy         (busy),
    .done         (done),
    .state        (state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_gen(input string tag);
    int n = 0;
    while (gen_enable !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_gen_seen"}, 64'(gen_enable), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, 64'(res_valid), 64'd1);
  endtask

  // Stub rwc_ctrl: answer three cycles after gen_enable, hold the word through CAPTURE.
  task automatic collide(input logic [31:0] w, input logic [31:0] c);
    wait_gen("collide");
    repeat (2) @(negedge clk);
    available = 1'b1;
    rsp_write = w;
    rsp_clean = c;
    @(negedge clk);
    available = 1'b0;
    check("gen_fall", 64'(gen_enable), 64'd0);
  endtask

  task automatic do_start(input logic [9:0] base, input logic [31:0] data, input logic sel);
    start       = 1'b1;
    base_addr   = base;
    cha_data_in = data;
    rsp_sel     = sel;
    @(negedge clk);
    start = 1'b0;
    check("start_state", 64'(state), 64'd1);
    check("start_busy_gen", 64'({busy, gen_enable}), 64'b11);
  endtask

  task automatic check_result(input string tag, input logic [0:0] idx, input logic [9:0] addr,
                              input logic [31:0] data, input logic [31:0] unst, input logic err);
    wait_valid(tag);
    check({tag, "_index"}, 64'(res_index), 64'(idx));
    check({tag, "_addr"}, 64'(cha_addr), 64'(addr));
    check({tag, "_data"}, 64'(res_data), 64'(data));
    check({tag, "_unstable"}, 64'(res_unstable), 64'(unst));
    check({tag, "_err"}, 64'(res_err), 64'(err));
    check({tag, "_gen_low"}, 64'(gen_enable), 64'd0);
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'({done, state}), 64'({1'b1, 3'd5}));
    @(negedge clk);
    check({tag, "_done_clear"}, 64'({done, busy, state}), 64'd0);
  endtask

  initial begin
    int          n_hi;
    logic        bp_ok;

    rst = 1'b1;
    start = 1'b0;
    rsp_sel = 1'b0;
    available = 1'b0;
    res_ready = 1'b1;
    cha_data_in = '0;
    rsp_write = '0;
    rsp_clean = '0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({gen_enable, res_valid, res_err, busy, done, state}), 64'd0);
    check("rst_addr_data", 64'({cha_addr, cha_data}), 64'd0);
    check("rst_payload", 64'({res_data, res_unstable}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Run 1: stable responder, base 3FF wraps to 000 on the second challenge.
    do_start(10'h3FF, 32'hDEAD_BEEF, 1'b0);
    start = 1'b1;
    base_addr = 10'h055;
    cha_data_in = 32'h0;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", 64'({cha_addr, cha_data}), 64'({10'h3FF, 32'hDEAD_BEEF}));
    check("busy_start_state", 64'(state), 64'd1);
    repeat (5) collide(32'hA5A5_0F0F, 32'h0);
    check_result("stable0", 1'b0, 10'h3FF, 32'hA5A5_0F0F, 32'h0, 1'b0);
    repeat (5) collide(32'hA5A5_0F0F, 32'h0);
    check_result("stable1", 1'b1, 10'h000, 32'hA5A5_0F0F, 32'h0, 1'b0);
    check_done("run1");

    // Run 2: challenge 0 times out under backpressure, challenge 1 is noisy on bit 0.
    res_ready = 1'b0;
    do_start(10'h010, 32'h1111_2222, 1'b0);
    wait_gen("tmo");
    n_hi = 1;
    @(negedge clk);
    while (gen_enable === 1'b1 && n_hi < 64) begin
      n_hi++;
      @(negedge clk);
    end
    check("tmo_gen_cycles", 64'(n_hi), 64'd8);
    check_result("tmo", 1'b0, 10'h010, 32'h0, 32'hFFFF_FFFF, 1'b1);
    available = 1'b1;
    bp_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || gen_enable !== 1'b0 || state !== 3'd4 || res_err !== 1'b1 ||
          res_data !== 32'h0 || res_unstable !== 32'hFFFF_FFFF || res_index !== 1'b0)
        bp_ok = 1'b0;
    end
    available = 1'b0;
    check("bp_stable", 64'(bp_ok), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    wait_gen("noisy_start");
    check("noisy_addr", 64'(cha_addr), 64'h011);
    check("noisy_index", 64'(res_index), 64'd1);
    collide(32'h1, 32'h0);
    collide(32'h1, 32'h0);
    collide(32'h0, 32'h0);
    collide(32'h1, 32'h0);
    collide(32'h0, 32'h0);
    check_result("noisy", 1'b1, 10'h011, 32'h1, 32'h1, 1'b0);
    check_done("run2");

    // Run 3: rsp_clean selected, then reset during SETTLE of the second repeat of challenge 1.
    do_start(10'h100, 32'h0BAD_F00D, 1'b1);
    repeat (5) collide(32'h0, 32'h1234_5678);
    check_result("clean", 1'b0, 10'h100, 32'h1234_5678, 32'h0, 1'b0);
    collide(32'h0, 32'h1234_5678);
    collide(32'h0, 32'h1234_5678);
    @(negedge clk);
    check("pre_rst_settle", 64'(state), 64'd3);
    rst = 1'b1;
    #1;
    check("midrst_ctrl", 64'({gen_enable, res_valid, res_err, busy, done, state}), 64'd0);
    check("midrst_addr_data", 64'({cha_addr, cha_data}), 64'd0);
    check("midrst_payload", 64'({res_index, res_data, res_unstable}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'({busy, state}), 64'd0);

    // Run 4: fresh run starts from index 0 with rsp_write selected again.
    do_start(10'h200, 32'h5555_AAAA, 1'b0);
    repeat (5) collide(32'hF0F0_F0F0, 32'h0);
    check_result("rerun0", 1'b0, 10'h200, 32'hF0F0_F0F0, 32'h0, 1'b0);
    repeat (5) collide(32'hF0F0_F0F0, 32'h0);
    check_result("rerun1", 1'b1, 10'h201, 32'hF0F0_F0F0, 32'h0, 1'b0);
    check_done("run4");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
